wordcount_multi_engine_ctrl: RTL and testbench

- Kernel-level control block that replaces the single-engine ap_start/ap_idle/ap_done logic with N parallel wordcount engines.
- On start it captures the scalar arguments and splits data_num words across C_NUM_ENGINES engines, handing each its own global-memory offset and word count. It kicks each engine, collects per-engine completion, then signals kernel done.
- Supports both SDx ap_ctrl_hs and ap_ctrl_chain (ap_continue) handshakes and reports a run cycle count.

---
 rtl/wordcount_multi_engine_ctrl.sv | 152 +++++++++++++++
 tb/tb_wordcount_multi_engine_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wordcount_multi_engine_ctrl.sv
// Kernel control for N parallel wordcount engines: splits data_num across the engines,
// kicks each one in turn, collects completions and reports ap_done in ap_ctrl_hs or ap_ctrl_chain style.
module wordcount_multi_engine_ctrl #(
  parameter int C_NUM_ENGINES     = 4,
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_WORDS_WIDTH     = 32,
  parameter int C_BYTES_PER_WORD  = 64,
  parameter int C_CTRL_CHAIN      = 0,
  parameter int C_CYCLE_CNT_WIDTH = 48
) (
  input  logic                                    ap_clk,
  input  logic                                    ap_rst_n,
  input  logic                                    ap_start,
  input  logic                                    ap_continue,
  output logic                                    ap_idle,
  output logic                                    ap_ready,
  output logic                                    ap_done,
  input  logic [C_WORDS_WIDTH-1:0]                data_num,
  input  logic [31:0]                             command,
  input  logic [C_ADDR_WIDTH-1:0]                 axi00_ptr0,
  output logic [C_NUM_ENGINES-1:0]                eng_kick,
  input  logic [C_NUM_ENGINES-1:0]                eng_done,
  output logic [C_NUM_ENGINES*C_ADDR_WIDTH-1:0]   eng_offset,
  output logic [C_NUM_ENGINES*C_WORDS_WIDTH-1:0]  eng_num,
  output logic [31:0]                             eng_command,
  output logic [C_CYCLE_CNT_WIDTH-1:0]            cycle_count,
  output logic                                    status_err
);

  localparam int LOG2_N   = $clog2(C_NUM_ENGINES);
  localparam int LOG2_BPW = $clog2(C_BYTES_PER_WORD);
  localparam int IDX_W    = (LOG2_N > 0) ? LOG2_N : 1;

  // state     | meaning
  // S_IDLE    | waiting for ap_start, ap_idle high
  // S_DISPATCH| one engine per cycle gets offset/count and a kick
  // S_WAIT    | waiting for all kicked engines to report done
  // S_DONE    | ap_done high; hs: one cycle, chain: until ap_continue
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_WAIT     = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic rst_meta;
  logic rst_sync_n;

  logic [1:0]                                    state;
  logic [IDX_W-1:0]                              idx;
  logic [C_WORDS_WIDTH-1:0]                      quot_q;
  logic [C_WORDS_WIDTH-1:0]                      rem_q;
  logic [C_ADDR_WIDTH-1:0]                       next_off;
  logic [C_NUM_ENGINES-1:0]                      pending;
  logic [C_NUM_ENGINES-1:0]                      kick_q;
  logic                                          ready_q;
  logic [C_NUM_ENGINES-1:0][C_ADDR_WIDTH-1:0]    off_q;
  logic [C_NUM_ENGINES-1:0][C_WORDS_WIDTH-1:0]   num_q;
  logic [31:0]                                   cmd_q;
  logic [C_CYCLE_CNT_WIDTH-1:0]                  cyc_q;
  logic                                          err_q;

  logic                                          accept;
  logic [C_WORDS_WIDTH-1:0]                      cur_cnt;
  logic [C_ADDR_WIDTH-1:0]                       cur_step;
  logic [C_NUM_ENGINES-1:0]                      set_mask;
  logic [C_NUM_ENGINES-1:0]                      spurious;

  // Assertion stays asynchronous so a mid-run reset aborts at once; release is synchronised.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  assign accept   = (state == S_IDLE) && ap_start;
  assign cur_cnt  = quot_q + ((C_WORDS_WIDTH'(idx) < rem_q) ? C_WORDS_WIDTH'(1) : '0);
  assign cur_step = C_ADDR_WIDTH'(cur_cnt) << LOG2_BPW;
  assign set_mask = ((state == S_DISPATCH) && (cur_cnt != '0)) ?
                    (C_NUM_ENGINES'(1) << idx) : '0;
  assign spurious = eng_done & ~pending;

  always_ff @(posedge ap_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      next_off <= '0;
      pending  <= '0;
      kick_q   <= '0;
      ready_q  <= 1'b0;
      off_q    <= '0;
      num_q    <= '0;
      cmd_q    <= '0;
      cyc_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      kick_q  <= set_mask;
      pending <= (pending & ~eng_done) | set_mask;
      err_q   <= (accept ? 1'b0 : err_q) | (|spurious);
      if (((state == S_DISPATCH) || (state == S_WAIT)) && (cyc_q != '1))
        cyc_q <= cyc_q + C_CYCLE_CNT_WIDTH'(1);

      case (state)
        S_IDLE: begin
          if (ap_start) begin
            quot_q   <= data_num >> LOG2_N;
            rem_q    <= data_num & C_WORDS_WIDTH'(C_NUM_ENGINES - 1);
            next_off <= axi00_ptr0;
            cmd_q    <= command;
            ready_q  <= 1'b1;
            cyc_q    <= '0;
            idx      <= '0;
            state    <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          off_q[idx] <= next_off;
          num_q[idx] <= cur_cnt;
          next_off   <= next_off + cur_step;
          if (idx == IDX_W'(C_NUM_ENGINES - 1))
            state <= S_WAIT;
          else
            idx <= idx + IDX_W'(1);
        end
        S_WAIT: begin
          if (pending == '0)
            state <= S_DONE;
        end
        default: begin
          if ((C_CTRL_CHAIN == 0) || ap_continue)
            state <= S_IDLE;
        end
      endcase
    end
  end

  assign ap_idle     = (state == S_IDLE);
  assign ap_done     = (state == S_DONE);
  assign ap_ready    = ready_q;
  assign eng_kick    = kick_q;
  assign eng_offset  = off_q;
  assign eng_num     = num_q;
  assign eng_command = cmd_q;
  assign cycle_count = cyc_q;
  assign status_err  = err_q;

endmodule

// File: tb/tb_wordcount_multi_engine_ctrl.sv
// Bench for wordcount_multi_engine_ctrl: table of partition vectors on an hs-mode instance,
// kick scoreboard, plus reset, spurious-done and chain-mode sequences.
module tb_wordcount_multi_engine_ctrl;
  localparam int N  = 4;
  localparam int AW = 64;
  localparam int WW = 32;
  localparam int CW = 48;

  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic              ap_rst_n;
  logic [WW-1:0]     data_num;
  logic [31:0]       command;
  logic [AW-1:0]     ptr;

  logic              hs_start, hs_continue, hs_idle, hs_ready, hs_done, hs_err;
  logic [N-1:0]      hs_kick, hs_eng_done;
  logic [N*AW-1:0]   hs_off;
  logic [N*WW-1:0]   hs_num;
  logic [31:0]       hs_cmd;
  logic [CW-1:0]     hs_cyc;

  logic              ch_start, ch_continue, ch_idle, ch_ready, ch_done, ch_err;
  logic [N-1:0]      ch_kick, ch_eng_done;
  logic [N*AW-1:0]   ch_off;
  logic [N*WW-1:0]   ch_num;
  logic [31:0]       ch_cmd;
  logic [CW-1:0]     ch_cyc;

  wordcount_multi_engine_ctrl #(.C_NUM_ENGINES(N), .C_ADDR_WIDTH(AW), .C_WORDS_WIDTH(WW),
    .C_BYTES_PER_WORD(64), .C_CTRL_CHAIN(0), .C_CYCLE_CNT_WIDTH(CW)) u_hs (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(hs_start), .ap_continue(hs_continue),
    .ap_idle(hs_idle), .ap_ready(hs_ready), .ap_done(hs_done), .data_num(data_num),
    .command(command), .axi00_ptr0(ptr), .eng_kick(hs_kick), .eng_done(hs_eng_done),
    .eng_offset(hs_off), .eng_num(hs_num), .eng_command(hs_cmd), .cycle_count(hs_cyc),
    .status_err(hs_err));

  wordcount_multi_engine_ctrl #(.C_NUM_ENGINES(N), .C_ADDR_WIDTH(AW), .C_WORDS_WIDTH(WW),
    .C_BYTES_PER_WORD(64), .C_CTRL_CHAIN(1), .C_CYCLE_CNT_WIDTH(CW)) u_ch (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ch_start), .ap_continue(ch_continue),
    .ap_idle(ch_idle), .ap_ready(ch_ready), .ap_done(ch_done), .data_num(data_num),
    .command(command), .axi00_ptr0(ptr), .eng_kick(ch_kick), .eng_done(ch_eng_done),
    .eng_offset(ch_off), .eng_num(ch_num), .eng_command(ch_cmd), .cycle_count(ch_cyc),
    .status_err(ch_err));

  typedef struct packed {
    logic [31:0]          dn;
    logic [63:0]          ptr;
    logic [31:0]          cmd;
    logic [N-1:0][7:0]    done_at;
    logic [N-1:0][31:0]   num;
    logic [N-1:0][63:0]   off;
    logic [7:0]           restart_at;
  } vec_t;

  typedef struct packed {
    logic [7:0]  idx;
    logic [7:0]  cyc;
    logic [31:0] num;
    logic [63:0] off;
  } kick_t;

  vec_t  vecs[7];
  kick_t sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int    last_done, exp_done, first_done, n_done, n_ready;
    kick_t e;
    last_done = 0;
    for (int i = 0; i < N; i++) begin
      if (v.num[i] != 0) sb_q.push_back({8'(i), 8'(i + 2), v.num[i], v.off[i]});
      if (int'(v.done_at[i]) > last_done) last_done = int'(v.done_at[i]);
    end
    exp_done   = (last_done + 2 > N + 2) ? last_done + 2 : N + 2;
    first_done = 0;
    n_done     = 0;
    n_ready    = 0;
    @(negedge ap_clk);
    data_num = v.dn; ptr = v.ptr; command = v.cmd; hs_start = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge ap_clk);
      if (c == 1) begin
        check("ready_after_accept", hs_ready, 1);
        check("idle_after_accept", hs_idle, 0);
      end
      n_ready += int'(hs_ready);
      if (hs_done) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      for (int i = 0; i < N; i++) begin
        if (hs_kick[i]) begin
          if (sb_q.size() == 0) check("kick_extra", hs_kick, 0);
          else begin
            e = sb_q.pop_front();
            check("kick_idx", i, e.idx);
            check("kick_cycle", c, e.cyc);
            check("kick_off", hs_off[i*AW +: AW], e.off);
            check("kick_num", hs_num[i*WW +: WW], e.num);
          end
        end
      end
      if (c == exp_done) begin
        check("cycle_count", hs_cyc, exp_done - 1);
        check("status_err_clear", hs_err, 0);
        check("eng_command", hs_cmd, v.cmd);
        for (int i = 0; i < N; i++) begin
          check("eng_offset", hs_off[i*AW +: AW], v.off[i]);
          check("eng_num", hs_num[i*WW +: WW], v.num[i]);
        end
      end
      if (c == exp_done + 1) check("idle_after_done", hs_idle, 1);
      hs_start = (c == int'(v.restart_at));
      for (int i = 0; i < N; i++) hs_eng_done[i] = (int'(v.done_at[i]) == c);
    end
    check("done_cycle", first_done, exp_done);
    check("done_pulses", n_done, 1);
    check("ready_pulses", n_ready, 1);
    check("kicks_missing", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_d1, n_d2, f1, f2;
    vecs[0] = '{32'd10, 64'h1000, 32'hC0DE0001, {8'd8, 8'd6, 8'd9, 8'd7},
                {32'd2, 32'd2, 32'd3, 32'd3}, {64'h1200, 64'h1180, 64'h10C0, 64'h1000}, 8'd0};
    vecs[1] = '{32'd2, 64'h2000, 32'hC0DE0002, {8'd0, 8'd0, 8'd7, 8'd6},
                {32'd0, 32'd0, 32'd1, 32'd1}, {64'h2080, 64'h2080, 64'h2040, 64'h2000}, 8'd0};
    vecs[2] = '{32'd0, 64'h3000, 32'hC0DE0003, {8'd0, 8'd0, 8'd0, 8'd0},
                {32'd0, 32'd0, 32'd0, 32'd0}, {64'h3000, 64'h3000, 64'h3000, 64'h3000}, 8'd0};
    vecs[3] = '{32'd8, 64'h4000, 32'hC0DE0004, {8'd9, 8'd8, 8'd7, 8'd3},
                {32'd2, 32'd2, 32'd2, 32'd2}, {64'h4180, 64'h4100, 64'h4080, 64'h4000}, 8'd0};
    vecs[4] = '{32'd7, 64'hFFFF_FFFF_FFFF_FF80, 32'hC0DE0005, {8'd6, 8'd6, 8'd6, 8'd6},
                {32'd1, 32'd2, 32'd2, 32'd2}, {64'h100, 64'h80, 64'h0, 64'hFFFF_FFFF_FFFF_FF80}, 8'd0};
    vecs[5] = '{32'd5, 64'h40, 32'hC0DE0006, {8'd6, 8'd6, 8'd5, 8'd4},
                {32'd1, 32'd1, 32'd1, 32'd2}, {64'h140, 64'h100, 64'hC0, 64'h40}, 8'd0};
    vecs[6] = '{32'd10, 64'h1000, 32'hC0DE0007, {8'd8, 8'd6, 8'd9, 8'd7},
                {32'd2, 32'd2, 32'd3, 32'd3}, {64'h1200, 64'h1180, 64'h10C0, 64'h1000}, 8'd7};

    ap_rst_n = 1'b0; hs_start = 1'b0; hs_continue = 1'b0; hs_eng_done = '0;
    ch_start = 1'b0; ch_continue = 1'b0; ch_eng_done = '0;
    data_num = '0; command = '0; ptr = '0;
    repeat (3) @(negedge ap_clk);
    check("rst_idle", hs_idle, 1);
    check("rst_ready", hs_ready, 0);
    check("rst_done", hs_done, 0);
    check("rst_kick", hs_kick, 0);
    check("rst_offset_or", |hs_off, 0);
    check("rst_num_or", |hs_num, 0);
    check("rst_command", hs_cmd, 0);
    check("rst_cycle_count", hs_cyc, 0);
    check("rst_status_err", hs_err, 0);
    check("rst_ch_idle", ch_idle, 1);
    ap_rst_n = 1'b1;
    repeat (4) @(negedge ap_clk);

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // spurious done in IDLE sets the sticky error; the next accept clears it
    hs_eng_done = 4'b1000;
    @(negedge ap_clk);
    hs_eng_done = '0;
    check("spurious_err", hs_err, 1);
    run_vec(vecs[6]);

    // reset asserted mid-WAIT
    @(negedge ap_clk);
    data_num = 32'd4; ptr = 64'h0; command = 32'h5; hs_start = 1'b1;
    @(negedge ap_clk);
    hs_start = 1'b0;
    repeat (6) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    check("midrun_rst_idle", hs_idle, 1);
    check("midrun_rst_kick", hs_kick, 0);
    check("midrun_rst_done", hs_done, 0);
    check("midrun_rst_num", |hs_num, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    n_d1 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge ap_clk);
      n_d1 += int'(hs_done);
    end
    check("no_done_after_rst", n_d1, 0);
    check("idle_after_rst", hs_idle, 1);
    hs_eng_done = 4'b0001;
    @(negedge ap_clk);
    hs_eng_done = '0;
    check("pending_cleared_by_rst", hs_err, 1);

    // chain mode: hold ap_done until ap_continue, ap_start held high re-accepted
    @(negedge ap_clk);
    data_num = 32'd0; ptr = 64'h8000; command = 32'h9; ch_start = 1'b1; ch_continue = 1'b0;
    n_d1 = 0; n_d2 = 0; f1 = 0; f2 = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge ap_clk);
      if (ch_done) begin
        if (c <= 11) begin n_d1++; if (f1 == 0) f1 = c; end
        else begin n_d2++; if (f2 == 0) f2 = c; end
      end
      if (c == 1)  check("ch_ready_first", ch_ready, 1);
      if (c == 6)  check("ch_cycle_count", ch_cyc, 5);
      if (c == 11) begin
        check("ch_idle_after_continue", ch_idle, 1);
        check("ch_done_after_continue", ch_done, 0);
      end
      if (c == 12) check("ch_ready_reaccept", ch_ready, 1);
      if (c == 18) check("ch_idle_second", ch_idle, 1);
      ch_continue = (c == 10) || (c >= 13);
      ch_start    = (c < 12);
    end
    check("ch_first_done_cycle", f1, 6);
    check("ch_done_held", n_d1, 5);
    check("ch_second_done_cycle", f2, 17);
    check("ch_second_done_len", n_d2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
